// File: rtl/output_job_scheduler_if.sv
// rtl/output_job_scheduler_if.sv - descriptor channel and stream-monitor bundle for output_job_scheduler
interface output_job_scheduler_if #(
   parameter int MAX_ADDR_WIDTH     = 13,
   parameter int NUM_CHANNELS_WIDTH = 7
);
   logic                          desc_valid;
   logic                          desc_ready;
   logic [MAX_ADDR_WIDTH-1:0]     desc_out_size;
   logic [2:0]                    desc_groups;
   logic [NUM_CHANNELS_WIDTH-1:0] desc_tag;
   logic                          mon_tvalid;
   logic                          mon_tready;
   logic                          mon_tlast;

   // producer side: compute controller plus the stream being snooped
   modport master (
      output desc_valid,
      output desc_out_size,
      output desc_groups,
      output desc_tag,
      output mon_tvalid,
      output mon_tready,
      output mon_tlast,
      input  desc_ready
   );

   // scheduler side
   modport slave (
      input  desc_valid,
      input  desc_out_size,
      input  desc_groups,
      input  desc_tag,
      input  mon_tvalid,
      input  mon_tready,
      input  mon_tlast,
      output desc_ready
   );
endinterface

// File: rtl/output_job_scheduler.sv
// rtl/output_job_scheduler.sv - queues output-stream jobs and sequences the output engine one job at a time
module output_job_scheduler #(
   parameter int MAX_ADDR_WIDTH     = 13,
   parameter int NUM_CHANNELS_WIDTH = 7,
   parameter int DESC_DEPTH         = 4,
   parameter int GAP_CYCLES         = 2,
   parameter int TIMEOUT_CYCLES     = 4096
) (
   input  logic                              m_axis_aclk,
   input  logic                              m_axis_aresetn,
   output_job_scheduler_if.slave             job_if,
   output logic                              start_output,
   output logic [MAX_ADDR_WIDTH-1:0]         out_size,
   output logic [2:0]                        groups,
   output logic                              job_done,
   output logic                              job_err,
   output logic [NUM_CHANNELS_WIDTH-1:0]     job_tag,
   output logic                              busy,
   output logic [$clog2(DESC_DEPTH+1)-1:0]   jobs_pending,
   output logic [MAX_ADDR_WIDTH-1:0]         beat_count
);
   localparam int PW = $clog2(DESC_DEPTH);
   localparam int CW = $clog2(DESC_DEPTH + 1);
   localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CW-1:0] FULL_CNT   = CW'(DESC_DEPTH);
   localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

   state_t                        state;
   state_t                        state_nxt;

   logic [MAX_ADDR_WIDTH-1:0]     fifo_size   [DESC_DEPTH];
   logic [2:0]                    fifo_groups [DESC_DEPTH];
   logic [NUM_CHANNELS_WIDTH-1:0] fifo_tag    [DESC_DEPTH];
   logic [PW-1:0]                 wr_ptr;
   logic [PW-1:0]                 rd_ptr;
   logic [CW-1:0]                 count;
   logic [CW-1:0]                 count_nxt;
   logic                          push;
   logic                          pop;

   logic [MAX_ADDR_WIDTH-1:0]     ld_size;
   logic [2:0]                    ld_groups;
   logic [NUM_CHANNELS_WIDTH-1:0] ld_tag;
   logic                          ld_valid;

   logic                          raw_beat;
   logic                          beat_q;
   logic                          last_q;
   logic [WW-1:0]                 wd_cnt;
   logic [GW-1:0]                 gap_cnt;
   logic                          wd_expire;
   logic                          run_done;

   logic                          start_nxt;
   logic                          done_nxt;
   logic                          err_nxt;
   logic                          busy_nxt;

   // desc_ready is registered, so a full FIFO refuses a push even when a pop happens on the same edge
   assign push      = job_if.desc_valid && job_if.desc_ready;
   assign pop       = (state == S_IDLE) && (count != '0);
   assign count_nxt = count + CW'(push) - CW'(pop);

   assign ld_valid  = (ld_size >= MAX_ADDR_WIDTH'(2)) && (ld_groups != 3'd0);
   assign raw_beat  = job_if.mon_tvalid && job_if.mon_tready && (state == S_RUN);
   assign run_done  = (state == S_RUN) && beat_q && last_q;
   assign wd_expire = (state == S_RUN) && !raw_beat && (wd_cnt == WD_LAST);

   assign jobs_pending = count;

   // descriptor storage, written only on an accepted push
   always_ff @(posedge m_axis_aclk) begin
      if (push) begin
         fifo_size[wr_ptr]   <= job_if.desc_out_size;
         fifo_groups[wr_ptr] <= job_if.desc_groups;
         fifo_tag[wr_ptr]    <= job_if.desc_tag;
      end
   end

   // FIFO pointers, occupancy and registered not-full
   always_ff @(posedge m_axis_aclk) begin
      if (!m_axis_aresetn) begin
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         count             <= '0;
         job_if.desc_ready <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count             <= count_nxt;
         job_if.desc_ready <= (count_nxt != FULL_CNT);
      end
   end

   // head entry captured at pop and held for the whole job
   always_ff @(posedge m_axis_aclk) begin
      if (!m_axis_aresetn) begin
         ld_size   <= '0;
         ld_groups <= '0;
         ld_tag    <= '0;
      end else if (pop) begin
         ld_size   <= fifo_size[rd_ptr];
         ld_groups <= fifo_groups[rd_ptr];
         ld_tag    <= fifo_tag[rd_ptr];
      end
   end

   // snooped handshake registered once; only beats seen while running are kept
   always_ff @(posedge m_axis_aclk) begin
      if (!m_axis_aresetn) begin
         beat_q <= 1'b0;
         last_q <= 1'b0;
      end else begin
         beat_q <= raw_beat;
         last_q <= raw_beat && job_if.mon_tlast;
      end
   end

   // watchdog counts beat-less RUN cycles; gap counter times the DRAIN idle window
   always_ff @(posedge m_axis_aclk) begin
      if (!m_axis_aresetn) begin
         wd_cnt  <= '0;
         gap_cnt <= '0;
      end else begin
         if ((state == S_RUN) && !raw_beat) wd_cnt <= wd_cnt + WW'(1);
         else                               wd_cnt <= '0;
         if (state == S_DRAIN) gap_cnt <= gap_cnt + GW'(1);
         else                  gap_cnt <= '0;
      end
   end

   // FSM state register
   always_ff @(posedge m_axis_aclk) begin
      if (!m_axis_aresetn) state <= S_IDLE;
      else                 state <= state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (pop) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = ld_valid ? S_RUN : S_DRAIN;
         S_RUN:   if (run_done || wd_expire) state_nxt = S_DRAIN;
         S_DRAIN: if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM output decode, one cycle ahead of the registered outputs
   always_comb begin
      start_nxt = (state_nxt == S_RUN);
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      if ((state == S_LOAD) && !ld_valid) begin
         done_nxt = 1'b1;
         err_nxt  = 1'b1;
      end else if (run_done) begin
         done_nxt = 1'b1;
      end else if (wd_expire) begin
         done_nxt = 1'b1;
         err_nxt  = 1'b1;
      end
      busy_nxt = (state_nxt != S_IDLE) || (count_nxt != '0);
   end

   // registered engine controls, job status and beat counter
   always_ff @(posedge m_axis_aclk) begin
      if (!m_axis_aresetn) begin
         start_output <= 1'b0;
         out_size     <= '0;
         groups       <= '0;
         job_done     <= 1'b0;
         job_err      <= 1'b0;
         job_tag      <= '0;
         busy         <= 1'b0;
         beat_count   <= '0;
      end else begin
         start_output <= start_nxt;
         job_done     <= done_nxt;
         job_err      <= err_nxt;
         busy         <= busy_nxt;
         if (done_nxt) job_tag <= ld_tag;
         if (state == S_LOAD) begin
            out_size   <= ld_size;
            groups     <= ld_groups;
            beat_count <= '0;
         end else if ((state == S_RUN) && beat_q && (beat_count != '1)) begin
            beat_count <= beat_count + MAX_ADDR_WIDTH'(1);
         end
      end
   end
endmodule

// File: doc/output_job_scheduler.md
# output_job_scheduler

Sequences output-stream jobs for the AXI-Stream output engine. Accepts job descriptors (element count, group factor, channel tag) from the compute controller and queues them in a small FIFO. Drives the engine's `start_output` / `out_size` / `groups` controls one job at a time. It snoops the master stream handshake to detect job completion, guarantees an idle gap between jobs so the engine's counters clear, and aborts a stalled job via watchdog.

## Interface
- `MAX_ADDR_WIDTH`, 13, width of SRAM address, `out_size` and the beat counter
- `NUM_CHANNELS_WIDTH`, 7, width of job tag (matches stream `tuser` width)
- `DESC_DEPTH`, 4, descriptor FIFO entries (power of two, ≥2)
- `GAP_CYCLES`, 2, cycles `start_output` is held low between jobs (≥1)
- `TIMEOUT_CYCLES`, 4096, RUN-state cycles without a stream beat before abort (≥2)
- `m_axis_aclk` in 1: sole clock, all logic on rising edge
- `m_axis_aresetn` in 1: synchronous, active-low reset
- `desc_valid` in 1: descriptor offered
- `desc_ready` out 1: FIFO can accept a descriptor
- `desc_out_size` in MAX_ADDR_WIDTH: job element count
- `desc_groups` in 3: results per SRAM word
- `desc_tag` in NUM_CHANNELS_WIDTH: job identifier
- `start_output` out 1: engine run enable
- `out_size` out MAX_ADDR_WIDTH: current job size to engine
- `groups` out 3: current job groups to engine
- `mon_tvalid`, `mon_tready`, `mon_tlast` in 1 each: copies of master stream handshake
- `job_done` out 1: one-cycle completion pulse
- `job_err` out 1: qualifies `job_done`; 1 = aborted or rejected
- `job_tag` out NUM_CHANNELS_WIDTH: tag of completed job, valid with `job_done`
- `busy` out 1: state ≠ IDLE or FIFO non-empty
- `jobs_pending` out $clog2(DESC_DEPTH+1): FIFO occupancy
- `beat_count` out MAX_ADDR_WIDTH: beats transferred in current/last job

## Operation
- FIFO push on `desc_valid && desc_ready`. `desc_ready` is registered and equals not-full after the push/pop of that edge. No push while full, even if a pop occurs the same cycle.
- FSM states: IDLE, LOAD, RUN, DRAIN.
- IDLE: when FIFO is non-empty, pop the head and go to LOAD.
- LOAD: latch `out_size`, `groups` and the tag from the popped entry. Clear `beat_count` and the watchdog.
  - Valid descriptor (`desc_out_size` ≥ 2 and `desc_groups` ≠ 0): go to RUN.
  - Invalid descriptor: pulse `job_done` with `job_err`=1, go to DRAIN. `start_output` is never raised.
- RUN: `start_output`=1.
  - Each beat (`mon_tvalid && mon_tready`) increments `beat_count` (saturating at all-ones) and clears the watchdog.
  - A beat with `mon_tlast`: pulse `job_done` with `job_err`=0, go to DRAIN.
  - Watchdog reaches TIMEOUT_CYCLES with no beat: pulse `job_done` with `job_err`=1, go to DRAIN.
- DRAIN: `start_output`=0 for exactly GAP_CYCLES cycles, then IDLE. Beats seen in DRAIN are ignored.
- `out_size` and `groups` hold their values through DRAIN and IDLE until the next LOAD.

## Timing
- Reset values: `desc_ready`=0, `start_output`=0, `out_size`=0, `groups`=0, `job_done`=0, `job_err`=0, `job_tag`=0, `busy`=0, `jobs_pending`=0, `beat_count`=0. FIFO is emptied and FSM = IDLE.
- First edge after reset release: `desc_ready`=1.
- All outputs are registered.
- Latency, descriptor push at edge N into an empty FIFO in IDLE:
  - pop at N+1, LOAD at N+1;
  - `start_output`=1 from N+2.
- tlast beat sampled at edge M: `job_done` high for cycle M+1 only, and `start_output`=0 from M+1.
- Next `start_output` rise is at the earliest M+1+GAP_CYCLES+2.
- Push and pop in the same cycle: `jobs_pending` unchanged.
- Reset asserted mid-job: `start_output` low at the next edge, queued jobs are discarded, and no `job_done` is issued.
- `job_done` never occurs on consecutive cycles.

## Test plan
- Reset, then push one job (size=10, groups=1, tag=5); engine model sends 9 beats with the last one tlast → `start_output` high 2 cycles after push, `job_done`=1/`job_err`=0/`job_tag`=5/`beat_count`=9, `start_output` low for ≥2 cycles.
- Push 5 descriptors back-to-back with no completions (DEPTH=4) → `desc_ready` drops after 4 accepted (one already popped into LOAD, so 5 accepted total); jobs complete in FIFO order with tags 0..4.
- Descriptor size=1, then groups=0 → each yields `job_done` with `job_err`=1, `start_output` never asserts, next queued valid job starts normally.
- RUN with `mon_tready` held 0 for TIMEOUT_CYCLES → `job_err`=1 exactly at the timeout, `start_output` drops, next job proceeds.
- Reset pulsed during RUN with 2 jobs queued → `start_output`=0, `jobs_pending`=0, `busy`=0 the cycle after reset, no `job_done`.
- Simultaneous push and pop at occupancy 2 → `jobs_pending` stays 2; beats arriving during DRAIN do not alter `beat_count`.
